div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for the EXE stage. Serves DIV.W, MOD.W, DIV.WU and MOD.WU, which the single-cycle ALU path does not handle.
- Uses a valid/ready handshake on both sides. The EXE stage stalls while the unit is busy, and the pipeline can flush it.
- Radix-2 restoring algorithm, one quotient bit per cycle. Signed operations are handled by sign/magnitude correction.

Parameters:
- DATA_W, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must be at least log2(DATA_W)+1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- div_valid  in  1  a request is presented.
- div_ready  out  1  the unit can accept a request; high only in IDLE.
- div_signed  in  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- div_src1  in  32  dividend (rj).
- div_src2  in  32  divisor (rk).
- div_cancel  in  1  pipeline flush; aborts any operation.
- out_valid  out  1  result available.
- out_ready  in  1  the consumer takes the result.
- div_quot  out  32  quotient.
- div_rem  out  32  remainder.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; div_ready=1; out_valid=0; div_quot=0; div_rem=0; counter=0.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - A request is accepted when div_valid & div_ready & ~div_cancel.
  - On accept, the unit latches |src1|, |src2|, sign_q = signed & (src1[31]^src2[31]), sign_r = signed & src1[31], and div_by_zero = (src2==0).
  - It clears the partial remainder, loads the counter with 32, and goes to CALC.
- CALC, each cycle:
  - {rem,dvd} is shifted left by 1.
  - trial = rem - divisor, computed at 33 bits.
  - If trial is non-negative, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - The counter decrements. When the counter reaches 1, the next state is DONE.
- Latency: exactly 32 CALC cycles. out_valid rises on cycle 33 after the accept edge.
- DONE:
  - Normal case: div_quot = sign_q ? -q : q; div_rem = sign_r ? -r : r. Both are registered on the CALC→DONE edge.
  - Divide by zero overrides the normal result: div_quot = 32'hFFFFFFFF and div_rem = the original div_src1, for both signed and unsigned.
  - Overflow case 0x80000000 / 0xFFFFFFFF, signed, falls out naturally: div_quot = 0x80000000, div_rem = 0. No special case is needed.
  - Outputs are held stable while out_valid & ~out_ready.
  - On out_ready the unit returns to IDLE. div_ready rises the following cycle; there is no same-cycle accept from DONE.
- div_cancel has priority over every other event, in every state:
  - Next state is IDLE and out_valid is 0 next cycle.
  - A result that was pending in DONE is discarded.
  - A request presented in the same cycle as div_cancel is ignored.
- reset during CALC or DONE: the unit returns to reset values next cycle and no result is produced.
- Operands are sampled only at accept. Changes on div_src* after accept have no effect.
- Remainder sign follows the dividend and quotient truncates toward zero, per the LoongArch definition.
- div_quot and div_rem are both always produced. The EXE stage selects between them by opcode.

Decomposition:
- Shared package (cpu_defs):
  - FSM state encodings DIV_IDLE, DIV_CALC, DIV_DONE.
  - Constants DIV_ITER=32 and DIV_ZERO_QUOT=32'hFFFFFFFF.
  - EXE-stage opcode-select constants for DIV/MOD.
- One natural sub-module: div_sign_fix. It is combinational: absolute value on input, conditional negate on output, two instances. Everything else stays in div_unit.

Test Plan:
- Unsigned 100/7, div_signed=0 → after 33 cycles out_valid=1, quot=14 (0x0000000E), rem=2; div_ready low throughout CALC.
- Signed −7/2 (0xFFFFFFF9/0x00000002) → quot=0xFFFFFFFD (−3), rem=0xFFFFFFFF (−1). Also 7/−2 → quot=0xFFFFFFFD, rem=0x00000001.
- Signed 0x80000000/0xFFFFFFFF → quot=0x80000000, rem=0. The same operands unsigned → quot=0x00000000, rem=0x80000000.
- Divide by zero, 0x12345678/0 with signed=1 and again with signed=0 → quot=0xFFFFFFFF, rem=0x12345678, latency still 33.
- div_cancel pulsed on CALC cycle 10 → next cycle IDLE, div_ready=1, no out_valid ever. A new request 20/3 then gives quot=6, rem=2.
- Backpressure: out_ready held low for 5 cycles in DONE → out_valid, quot and rem stable. div_valid is ignored during that time. The unit accepts the next request one cycle after the out_ready handshake.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared EXE-stage definitions for the multi-cycle divider:
// FSM encodings, iteration constants and opcode-select codes.
package cpu_defs;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int          DIV_ITER      = 32;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    // EXE-stage select codes: bit 1 = unsigned, bit 0 = take remainder
    localparam logic [1:0] EXE_DIVSEL_DIV_W  = 2'd0;
    localparam logic [1:0] EXE_DIVSEL_MOD_W  = 2'd1;
    localparam logic [1:0] EXE_DIVSEL_DIV_WU = 2'd2;
    localparam logic [1:0] EXE_DIVSEL_MOD_WU = 2'd3;

    function automatic logic divsel_is_signed(input logic [1:0] sel);
        return ~sel[1];
    endfunction

    function automatic logic divsel_takes_rem(input logic [1:0] sel);
        return sel[0];
    endfunction

endpackage

// File: rtl/div_unit_sign_fix.sv
// Combinational sign correction for a pair of operands: each value is
// two's-complement negated when its flag is set (abs on input, fix-up on output).
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg_a,
    input  logic [W-1:0] b,
    input  logic         neg_b,
    output logic [W-1:0] y_a,
    output logic [W-1:0] y_b
);

    // Conditional negate of both lanes
    always_comb begin
        if (neg_a) begin
            y_a = {W{1'b0}} - a;
        end else begin
            y_a = a;
        end
        if (neg_b) begin
            y_b = {W{1'b0}} - b;
        end else begin
            y_b = b;
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV.W/MOD.W/DIV.WU/MOD.WU with
// valid/ready on both sides, flush via div_cancel and sign/magnitude correction.
module div_unit
    import cpu_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic              div_signed,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              div_cancel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] div_quot,
    output logic [DATA_W-1:0] div_rem
);

    div_state_e        state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] dvd_r;
    logic [DATA_W-1:0] dsr_r;
    logic [DATA_W-1:0] src1_r;
    logic              sign_q_r;
    logic              sign_r_r;
    logic              dbz_r;

    logic [DATA_W-1:0] abs1_s;
    logic [DATA_W-1:0] abs2_s;
    logic [DATA_W:0]   trial_s;
    logic              q_bit_s;
    logic [DATA_W-1:0] rem_nx_s;
    logic [DATA_W-1:0] dvd_nx_s;
    logic [DATA_W-1:0] quot_fix_s;
    logic [DATA_W-1:0] rem_fix_s;

    div_sign_fix #(.W(DATA_W)) u_abs_in (
        .a     (div_src1),
        .neg_a (div_signed & div_src1[DATA_W-1]),
        .b     (div_src2),
        .neg_b (div_signed & div_src2[DATA_W-1]),
        .y_a   (abs1_s),
        .y_b   (abs2_s)
    );

    div_sign_fix #(.W(DATA_W)) u_fix_out (
        .a     (dvd_nx_s),
        .neg_a (sign_q_r),
        .b     (rem_nx_s),
        .neg_b (sign_r_r),
        .y_a   (quot_fix_s),
        .y_b   (rem_fix_s)
    );

    // One restoring step: the shifted remainder can reach 33 bits, so the
    // trial subtraction is one bit wider and its MSB is the borrow.
    always_comb begin
        trial_s  = {rem_r, dvd_r[DATA_W-1]} - {1'b0, dsr_r};
        q_bit_s  = ~trial_s[DATA_W];
        if (q_bit_s) begin
            rem_nx_s = trial_s[DATA_W-1:0];
        end else begin
            rem_nx_s = {rem_r[DATA_W-2:0], dvd_r[DATA_W-1]};
        end
        dvd_nx_s = {dvd_r[DATA_W-2:0], q_bit_s};
    end

    // Control FSM, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= DIV_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {DATA_W{1'b0}};
            dvd_r     <= {DATA_W{1'b0}};
            dsr_r     <= {DATA_W{1'b0}};
            src1_r    <= {DATA_W{1'b0}};
            sign_q_r  <= 1'b0;
            sign_r_r  <= 1'b0;
            dbz_r     <= 1'b0;
            div_ready <= 1'b1;
            out_valid <= 1'b0;
            div_quot  <= {DATA_W{1'b0}};
            div_rem   <= {DATA_W{1'b0}};
        end else if (div_cancel) begin
            state_r   <= DIV_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            div_ready <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (div_valid && div_ready) begin
                        dvd_r     <= abs1_s;
                        dsr_r     <= abs2_s;
                        src1_r    <= div_src1;
                        sign_q_r  <= div_signed & (div_src1[DATA_W-1] ^ div_src2[DATA_W-1]);
                        sign_r_r  <= div_signed & div_src1[DATA_W-1];
                        dbz_r     <= (div_src2 == {DATA_W{1'b0}});
                        rem_r     <= {DATA_W{1'b0}};
                        cnt_r     <= CNT_W'(DIV_ITER);
                        div_ready <= 1'b0;
                        state_r   <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    rem_r <= rem_nx_s;
                    dvd_r <= dvd_nx_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    // Last iteration: the result leaves straight from the step logic
                    if (cnt_r == CNT_W'(1)) begin
                        state_r   <= DIV_DONE;
                        out_valid <= 1'b1;
                        if (dbz_r) begin
                            div_quot <= DIV_ZERO_QUOT;
                            div_rem  <= src1_r;
                        end else begin
                            div_quot <= quot_fix_s;
                            div_rem  <= rem_fix_s;
                        end
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state_r   <= DIV_IDLE;
                        out_valid <= 1'b0;
                        div_ready <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= DIV_IDLE;
                    out_valid <= 1'b0;
                    div_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed table, flush/reset/backpressure
// sequences and random operands checked against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] div_src1;
    logic [31:0] div_src2;
    logic        div_cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] div_quot;
    logic [31:0] div_rem;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[11];

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .div_cancel (div_cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string nm);
        chk({nm, "_ready_idle"}, div_ready, 1'b1);
        div_valid  = 1'b1;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        tick();
        div_valid  = 1'b0;
        div_signed = ~sgn;
        div_src1   = $urandom;
        div_src2   = $urandom;
    endtask

    task automatic finish_op(input logic [31:0] eq, input logic [31:0] er, input string nm);
        int bad;
        bad = 0;
        for (int k = 0; k < 31; k++) begin
            tick();
            if (out_valid !== 1'b0 || div_ready !== 1'b0) bad++;
        end
        chk({nm, "_busy_window"}, bad, 32'd0);
        tick();
        chk({nm, "_out_valid"}, out_valid, 1'b1);
        chk({nm, "_quot"}, div_quot, eq);
        chk({nm, "_rem"}, div_rem, er);
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, out_valid, 1'b0);
        chk({nm, "_ready_back"}, div_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;
        int          bad;

        tbl[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000_000E, 32'd2};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1};
        tbl[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 32'd0};
        tbl[4]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
        tbl[5]  = '{1'b1, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 32'h1234_5678};
        tbl[6]  = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF, 32'h1234_5678};
        tbl[7]  = '{1'b0, 32'd20,         32'd3,          32'd6,         32'd2};
        tbl[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE};
        tbl[9]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 32'd0};
        tbl[10] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF, 32'hFFFF_FFFF};

        reset      = 1'b1;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        div_src1   = 32'd0;
        div_src2   = 32'd0;
        div_cancel = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        chk("rst_ready", div_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_quot", div_quot, 32'd0);
        chk("rst_rem", div_rem, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            start_op(tbl[i].sgn, tbl[i].a, tbl[i].b, $sformatf("vec%0d", i));
            finish_op(tbl[i].q, tbl[i].r, $sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        // Flush on CALC cycle 10 with a competing request in the same cycle
        start_op(1'b0, 32'd100, 32'd7, "cancel");
        repeat (9) tick();
        div_cancel = 1'b1;
        div_valid  = 1'b1;
        div_src1   = 32'd5;
        div_src2   = 32'd1;
        tick();
        div_cancel = 1'b0;
        div_valid  = 1'b0;
        chk("cancel_ready", div_ready, 1'b1);
        chk("cancel_out_valid", out_valid, 1'b0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0 || div_ready !== 1'b1) bad++;
        end
        chk("cancel_no_result", bad, 32'd0);
        start_op(1'b0, 32'd20, 32'd3, "after_cancel");
        finish_op(32'd6, 32'd2, "after_cancel");
        drain("after_cancel");

        // Request together with a flush in IDLE is ignored
        div_valid  = 1'b1;
        div_cancel = 1'b1;
        div_src1   = 32'd9;
        div_src2   = 32'd3;
        tick();
        div_valid  = 1'b0;
        div_cancel = 1'b0;
        chk("cancel_idle_ignored", div_ready, 1'b1);

        // Flush discards a pending result in DONE
        start_op(1'b1, 32'hFFFF_FFF9, 32'd2, "cancel_done");
        finish_op(32'hFFFF_FFFD, 32'hFFFF_FFFF, "cancel_done");
        div_cancel = 1'b1;
        tick();
        div_cancel = 1'b0;
        chk("cancel_done_valid", out_valid, 1'b0);
        chk("cancel_done_ready", div_ready, 1'b1);

        // Reset in the middle of CALC
        start_op(1'b0, 32'd1000, 32'd3, "rst_calc");
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_calc_ready", div_ready, 1'b1);
        chk("rst_calc_valid", out_valid, 1'b0);
        chk("rst_calc_quot", div_quot, 32'd0);
        chk("rst_calc_rem", div_rem, 32'd0);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        chk("rst_calc_no_result", bad, 32'd0);

        // Backpressure in DONE while a new request waits
        start_op(1'b0, 32'd1000, 32'd10, "bp");
        finish_op(32'd100, 32'd0, "bp");
        div_valid  = 1'b1;
        div_signed = 1'b0;
        div_src1   = 32'd55;
        div_src2   = 32'd5;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid !== 1'b1 || div_quot !== 32'd100 || div_rem !== 32'd0 || div_ready !== 1'b0) bad++;
        end
        chk("bp_hold_stable", bad, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_handshake_valid", out_valid, 1'b0);
        chk("bp_handshake_ready", div_ready, 1'b1);
        start_op(1'b0, 32'd55, 32'd5, "bp_next");
        finish_op(32'd11, 32'd0, "bp_next");
        drain("bp_next");

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'd0 - 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(rs, ra, rb, eq, er);
            start_op(rs, ra, rb, $sformatf("rnd%0d", i));
            finish_op(eq, er, $sformatf("rnd%0d", i));
            drain($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
